// File: rtl/bin_to_bcd_seq_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
// Contents: FSM state enum, add-3 correction constants, and a helper that
// returns the minimum number of BCD digits able to hold any BIN_W-bit value.
package bin2bcd_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic [3:0] BCD_ADD3_THRESH = 4'd5;
    localparam logic [3:0] BCD_ADD3_VAL    = 4'd3;

    // ceil(w * log10(2)) using a fixed-point approximation of log10(2)
    function automatic int unsigned digits_for_width(input int unsigned w);
        return (w * 32'd30103 + 32'd99999) / 32'd100000;
    endfunction

endpackage

// File: rtl/bin_to_bcd_seq_if.sv
// Handshake bundle between a producer/consumer and bin_to_bcd_seq.
// Signals:
//   in_valid / in_ready / bin_in     : operand channel (producer -> converter)
//   out_valid / out_ready / bcd_out  : result channel (converter -> consumer)
//   ovf                              : overflow flag, present only with BIN2BCD_OVF_EN
// Modports: master = producer/consumer side, slave = converter side.
interface bin_to_bcd_seq_if #(
    parameter int unsigned BIN_W  = 8,
    parameter int unsigned DIGITS = 3
);

    logic                  in_valid;
    logic                  in_ready;
    logic [BIN_W-1:0]      bin_in;
    logic                  out_valid;
    logic                  out_ready;
    logic [4*DIGITS-1:0]   bcd_out;
`ifdef BIN2BCD_OVF_EN
    logic                  ovf;

    modport master (
        output in_valid, bin_in, out_ready,
        input  in_ready, out_valid, bcd_out, ovf
    );

    modport slave (
        input  in_valid, bin_in, out_ready,
        output in_ready, out_valid, bcd_out, ovf
    );
`else
    modport master (
        output in_valid, bin_in, out_ready,
        input  in_ready, out_valid, bcd_out
    );

    modport slave (
        input  in_valid, bin_in, out_ready,
        output in_ready, out_valid, bcd_out
    );
`endif

endinterface

// File: rtl/bin_to_bcd_seq_add3.sv
// bcd_add3_digit: combinational double-dabble correction cell.
// Ports:
//   digit_i   : current 4-bit BCD digit
//   digit_o_c : digit + 3 when digit >= 5, otherwise unchanged (4-bit wrap)
module bcd_add3_digit
    import bin2bcd_pkg::*;
(
    input  logic [3:0] digit_i,
    output logic [3:0] digit_o_c
);

    always_comb begin
        digit_o_c = digit_i;
        if (digit_i >= BCD_ADD3_THRESH) begin
            digit_o_c = digit_i + BCD_ADD3_VAL;
        end
    end

endmodule

// File: rtl/bin_to_bcd_seq.sv
// bin_to_bcd_seq: sequential binary-to-BCD converter (shift-and-add-3),
// one operand bit per clock, valid/ready on both sides.
// Ports:
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset
//   bus_io : bin_to_bcd_seq_if.slave (in_valid/in_ready/bin_in,
//            out_valid/out_ready/bcd_out, and ovf when enabled)
// Optional feature macro: BIN2BCD_OVF_EN adds a sticky overflow flag that
// records any 1 shifted out of the top BCD digit during conversion.
module bin_to_bcd_seq
    import bin2bcd_pkg::*;
#(
    parameter int unsigned BIN_W  = 8,
    parameter int unsigned DIGITS = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    bin_to_bcd_seq_if.slave    bus_io
);

    localparam int unsigned ACC_W = 4 * DIGITS;
    localparam int unsigned CNT_W = $clog2(BIN_W + 1);

    state_e             state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [BIN_W-1:0]   sh_q, sh_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [ACC_W-1:0]   bcd_q, bcd_d;
    logic               in_ready_q, in_ready_d;
    logic               out_valid_q, out_valid_d;
    logic [ACC_W-1:0]   acc_corr_c;
`ifdef BIN2BCD_OVF_EN
    logic               sticky_q, sticky_d;
    logic               ovf_q, ovf_d;
`else
    logic               unused_msb_c;
    assign unused_msb_c = acc_corr_c[ACC_W-1];
`endif

    // Per-digit add-3 correction applied before every shift
    for (genvar g = 0; g < int'(DIGITS); g++) begin : g_digit
        bcd_add3_digit u_add3 (
            .digit_i   (acc_q[4*g +: 4]),
            .digit_o_c (acc_corr_c[4*g +: 4])
        );
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            sh_q        <= '0;
            cnt_q       <= '0;
            bcd_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
`ifdef BIN2BCD_OVF_EN
            sticky_q    <= 1'b0;
            ovf_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            sh_q        <= sh_d;
            cnt_q       <= cnt_d;
            bcd_q       <= bcd_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
`ifdef BIN2BCD_OVF_EN
            sticky_q    <= sticky_d;
            ovf_q       <= ovf_d;
`endif
        end
    end

    // Next-state and datapath logic
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        sh_d    = sh_q;
        cnt_d   = cnt_q;
        bcd_d   = bcd_q;
`ifdef BIN2BCD_OVF_EN
        sticky_d = sticky_q;
        ovf_d    = ovf_q;
`endif

        unique case (state_q)
            IDLE: begin
                if (bus_io.in_valid) begin
                    sh_d    = bus_io.bin_in;
                    acc_d   = '0;
                    cnt_d   = '0;
`ifdef BIN2BCD_OVF_EN
                    sticky_d = 1'b0;
`endif
                    state_d = CONV;
                end
            end
            CONV: begin
                // Shift {corrected acc, bin_sh} left by one
                acc_d = {acc_corr_c[ACC_W-2:0], sh_q[BIN_W-1]};
                sh_d  = {sh_q[BIN_W-2:0], 1'b0};
                cnt_d = cnt_q + CNT_W'(1);
`ifdef BIN2BCD_OVF_EN
                sticky_d = sticky_q | acc_corr_c[ACC_W-1];
`endif
                // Last shift happens on this edge; publish its result
                if (cnt_q == CNT_W'(BIN_W - 1)) begin
                    state_d = DONE;
                    bcd_d   = acc_d;
`ifdef BIN2BCD_OVF_EN
                    ovf_d   = sticky_d;
`endif
                end
            end
            DONE: begin
                if (bus_io.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == DONE);
    end

    assign bus_io.in_ready  = in_ready_q;
    assign bus_io.out_valid = out_valid_q;
    assign bus_io.bcd_out   = bcd_q;
`ifdef BIN2BCD_OVF_EN
    assign bus_io.ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Self-checking bench for bin_to_bcd_seq. Expected results come from a
// decimal-arithmetic reference model (repeated /10, %10).
module tb_bin_to_bcd_seq;

    localparam int unsigned BIN_W  = 8;
`ifdef BIN2BCD_OVF_EN
    localparam int unsigned DIGITS = 2;
`else
    localparam int unsigned DIGITS = 3;
`endif
    localparam int unsigned BCD_W  = 4 * DIGITS;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    bin_to_bcd_seq_if #(.BIN_W(BIN_W), .DIGITS(DIGITS)) bus ();

    bin_to_bcd_seq #(.BIN_W(BIN_W), .DIGITS(DIGITS)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .bus_io (bus)
    );

    // Reference: low DIGITS decimal digits of v, packed 4 bits per digit
    function automatic logic [BCD_W-1:0] bcd_model(input int unsigned v);
        logic [BCD_W-1:0] r;
        int unsigned x;
        r = '0;
        x = v;
        for (int i = 0; i < int'(DIGITS); i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

`ifdef BIN2BCD_OVF_EN
    function automatic logic ovf_model(input int unsigned v);
        int unsigned lim;
        lim = 1;
        for (int i = 0; i < int'(DIGITS); i++) lim = lim * 10;
        return (v >= lim);
    endfunction
`endif

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one operand; returns the cycle number of the accept edge
    task automatic send_op(input logic [BIN_W-1:0] v, output int acc_cyc);
        int k;
        k = 0;
        while (bus.in_ready !== 1'b1 && k < 50) begin
            tick();
            k++;
        end
        if (bus.in_ready !== 1'b1) begin
            n_checks++;
            n_fail++;
            $display("FAIL send_op_timeout: in_ready=%b after %0d cycles, required 1", bus.in_ready, k);
        end
        bus.in_valid = 1'b1;
        bus.bin_in   = v;
        tick();
        acc_cyc      = cyc;
        bus.in_valid = 1'b0;
    endtask

    // Cycles from the current point until out_valid is seen; -1 on timeout
    task automatic wait_valid(output int lat);
        lat = -1;
        for (int n = 1; n <= 4 * int'(BIN_W); n++) begin
            tick();
            if (bus.out_valid === 1'b1) begin
                lat = n;
                break;
            end
        end
    endtask

    task automatic handshake();
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        n_checks++;
        if (bus.in_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_in_ready: got %b, required 1", bus.in_ready);
        end
        n_checks++;
        if (bus.out_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_out_valid: got %b, required 0", bus.out_valid);
        end
        n_checks++;
        if (bus.bcd_out !== '0) begin
            n_fail++; $display("FAIL reset_bcd_out: got %h, required 0", bus.bcd_out);
        end
`ifdef BIN2BCD_OVF_EN
        n_checks++;
        if (bus.ovf !== 1'b0) begin
            n_fail++; $display("FAIL reset_ovf: got %b, required 0", bus.ovf);
        end
`endif
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        int a, lat;
        send_op(BIN_W'(255), a);
        wait_valid(lat);
        n_checks++;
        if (lat !== int'(BIN_W)) begin
            n_fail++; $display("FAIL basic_latency: got %0d, required %0d", lat, BIN_W);
        end
        n_checks++;
        if (bus.bcd_out !== bcd_model(255)) begin
            n_fail++; $display("FAIL basic_255: got %h, required %h", bus.bcd_out, bcd_model(255));
        end
        handshake();
        n_checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            n_fail++; $display("FAIL basic_after_hs: in_ready=%b out_valid=%b, required 1/0", bus.in_ready, bus.out_valid);
        end
    endtask

    task automatic test_zero_one();
        int a, lat;
        send_op(BIN_W'(0), a);
        wait_valid(lat);
        n_checks++;
        if (bus.bcd_out !== bcd_model(0)) begin
            n_fail++; $display("FAIL zero_value: got %h, required %h", bus.bcd_out, bcd_model(0));
        end
        handshake();
        send_op(BIN_W'(1), a);
        tick(); tick(); tick();
        n_checks++;
        if (bus.bcd_out !== bcd_model(0)) begin
            n_fail++; $display("FAIL zero_held_in_conv: got %h, required %h", bus.bcd_out, bcd_model(0));
        end
        wait_valid(lat);
        n_checks++;
        if (lat !== int'(BIN_W) - 3) begin
            n_fail++; $display("FAIL one_latency: got %0d, required %0d", lat, int'(BIN_W) - 3);
        end
        n_checks++;
        if (bus.bcd_out !== bcd_model(1)) begin
            n_fail++; $display("FAIL one_value: got %h, required %h", bus.bcd_out, bcd_model(1));
        end
        handshake();
    endtask

    task automatic test_backpressure();
        int a, lat;
        send_op(BIN_W'(99), a);
        wait_valid(lat);
        for (int i = 0; i < 5; i++) begin
            if (i == 1) begin
                bus.in_valid = 1'b1;
                bus.bin_in   = BIN_W'(42);
            end
            if (i == 3) bus.in_valid = 1'b0;
            tick();
            n_checks++;
            if (bus.out_valid !== 1'b1 || bus.bcd_out !== bcd_model(99) || bus.in_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL hold_99_cycle%0d: out_valid=%b bcd=%h in_ready=%b, required 1/%h/0",
                         i, bus.out_valid, bus.bcd_out, bus.in_ready, bcd_model(99));
            end
        end
        handshake();
        n_checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            n_fail++; $display("FAIL hold_after_hs: in_ready=%b out_valid=%b, required 1/0", bus.in_ready, bus.out_valid);
        end
        send_op(BIN_W'(123), a);
        wait_valid(lat);
        n_checks++;
        if (bus.bcd_out !== bcd_model(123) || lat !== int'(BIN_W)) begin
            n_fail++; $display("FAIL after_ignored_42: got %h lat %0d, required %h lat %0d",
                               bus.bcd_out, lat, bcd_model(123), BIN_W);
        end
        handshake();
    endtask

    task automatic test_reset_midconv();
        int a, lat;
        send_op(BIN_W'(200), a);
        tick(); tick(); tick();
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.bcd_out !== '0) begin
            n_fail++; $display("FAIL midconv_reset: in_ready=%b out_valid=%b bcd=%h, required 1/0/0",
                               bus.in_ready, bus.out_valid, bus.bcd_out);
        end
        tick();
        rst_n = 1'b1;
        tick();
        send_op(BIN_W'(7), a);
        wait_valid(lat);
        n_checks++;
        if (bus.bcd_out !== bcd_model(7) || lat !== int'(BIN_W)) begin
            n_fail++; $display("FAIL post_reset_7: got %h lat %0d, required %h lat %0d",
                               bus.bcd_out, lat, bcd_model(7), BIN_W);
        end
        handshake();
    endtask

    task automatic test_back_to_back();
        int a0, a1, lat;
        send_op(BIN_W'(58), a0);
        wait_valid(lat);
        handshake();
        send_op(BIN_W'(131), a1);
        n_checks++;
        if (a1 - a0 !== int'(BIN_W) + 2) begin
            n_fail++; $display("FAIL b2b_spacing: got %0d, required %0d", a1 - a0, BIN_W + 2);
        end
        wait_valid(lat);
        n_checks++;
        if (bus.bcd_out !== bcd_model(131)) begin
            n_fail++; $display("FAIL b2b_value: got %h, required %h", bus.bcd_out, bcd_model(131));
        end
        handshake();
    endtask

    task automatic test_sweep();
        int a, lat;
        logic [3:0] dg;
        for (int v = 0; v < (1 << BIN_W); v++) begin
            send_op(BIN_W'(v), a);
            wait_valid(lat);
            n_checks++;
            if (bus.bcd_out !== bcd_model(v)) begin
                n_fail++; $display("FAIL sweep_%0d: got %h, required %h", v, bus.bcd_out, bcd_model(v));
            end
            for (int d = 0; d < int'(DIGITS); d++) begin
                dg = bus.bcd_out[4*d +: 4];
                n_checks++;
                if (!(dg <= 4'd9)) begin
                    n_fail++; $display("FAIL sweep_digit_%0d_%0d: got %0d, required <=9", v, d, dg);
                end
            end
`ifdef BIN2BCD_OVF_EN
            n_checks++;
            if (bus.ovf !== ovf_model(v)) begin
                n_fail++; $display("FAIL sweep_ovf_%0d: got %b, required %b", v, bus.ovf, ovf_model(v));
            end
`endif
            handshake();
        end
    endtask

    task automatic test_random();
        int a, lat, v, hold;
        for (int t = 0; t < 30; t++) begin
            v    = int'($urandom_range((1 << BIN_W) - 1, 0));
            hold = int'($urandom_range(3, 0));
            for (int g = 0; g < int'($urandom_range(2, 0)); g++) tick();
            send_op(BIN_W'(v), a);
            wait_valid(lat);
            n_checks++;
            if (bus.bcd_out !== bcd_model(v) || lat !== int'(BIN_W)) begin
                n_fail++; $display("FAIL rand_%0d: got %h lat %0d, required %h lat %0d",
                                   v, bus.bcd_out, lat, bcd_model(v), BIN_W);
            end
            for (int h = 0; h < hold; h++) begin
                tick();
                n_checks++;
                if (bus.out_valid !== 1'b1 || bus.bcd_out !== bcd_model(v)) begin
                    n_fail++; $display("FAIL rand_hold_%0d: out_valid=%b bcd=%h, required 1/%h",
                                       v, bus.out_valid, bus.bcd_out, bcd_model(v));
                end
            end
            handshake();
        end
    endtask

`ifdef BIN2BCD_OVF_EN
    task automatic test_ovf();
        int a, lat;
        int unsigned vals [3]  = '{99, 100, 255};
        logic [7:0]  exp_b [3] = '{8'h99, 8'h00, 8'h55};
        logic        exp_o [3] = '{1'b0, 1'b1, 1'b1};
        for (int i = 0; i < 3; i++) begin
            send_op(BIN_W'(vals[i]), a);
            wait_valid(lat);
            n_checks++;
            if (bus.bcd_out !== BCD_W'(exp_b[i]) || bus.ovf !== exp_o[i]) begin
                n_fail++; $display("FAIL ovf_%0d: got %h/%b, required %h/%b",
                                   vals[i], bus.bcd_out, bus.ovf, exp_b[i], exp_o[i]);
            end
            handshake();
        end
    endtask
`endif

    initial begin
        bus.in_valid  = 1'b0;
        bus.bin_in    = '0;
        bus.out_ready = 1'b0;
        test_reset();
        test_basic();
        test_zero_one();
        test_backpressure();
        test_reset_midconv();
        test_back_to_back();
`ifdef BIN2BCD_OVF_EN
        test_ovf();
`endif
        test_sweep();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
